tge_pkt_sim_ctrl: RTL
=====================

# tge_pkt_sim_ctrl

Packet-simulator controller that sequences the 10GbE transmit datapath in the tge tutorial design. It is gated by the software `pkt_sim_enable` register and emits fixed-length test packets at a programmable start-to-start period. Each packet carries a packet sequence number and a word index. The block honours the core's almost-full backpressure and exposes packet and late-start counters to software registers.

## Interface

Parameters:
- `LEN_W`, 16: width of the payload-length field, in 64-bit words.
- `PER_W`, 32: width of the period field, in clock cycles.

Ports:
- `user_clk`, in, 1: fabric clock shared with the TGE tx interface.
- `user_rst_n`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: bit 0 of the `pkt_sim_enable` register, already in the `user_clk` domain.
- `payload_len`, in, `LEN_W`: words per packet; 0 is treated as 1.
- `period`, in, `PER_W`: cycles from one packet start to the next; 0 is treated as 1.
- `tx_afull`, in, 1: TGE tx FIFO almost-full.
- `tx_valid`, out, 1: data word valid.
- `tx_data`, out, 64: `{pkt_seq[31:0], word_idx[31:0]}`.
- `tx_eof`, out, 1: last word of the packet, coincident with `tx_valid`.
- `pkt_count`, out, 32: number of completed packets (eof words issued).
- `late_count`, out, 32: number of periods whose start came due while a packet was still sending.
- `busy`, out, 1: high when the state is not IDLE.

## Operation

- States:
  - **IDLE.** Wait for `enable`=1. Then go to SEND, latch `payload_len` and `period`, clear the period timer, and clear `word_idx`.
  - **SEND.**
    - Each cycle with `tx_afull`=0, issue one word and increment `word_idx`.
    - The word with `word_idx` = len-1 has `tx_eof`=1.
    - After eof, increment `pkt_seq` and `pkt_count`, then go to GAP.
  - **GAP.**
    - If `enable`=0, go to IDLE.
    - When the timer ≥ period-1, start the next packet: re-latch len and period, clear the timer, and go to SEND.
- Period timer:
  - Free-runs from the SEND entry cycle and saturates at all-ones.
  - If it reaches period-1 while still in SEND, increment `late_count` once for that period.
  - The next packet then starts in the cycle after eof, giving back-to-back packets.
- Dropping `enable` mid-packet always completes the current packet, then goes to IDLE. Packets are never truncated.
- `payload_len` and `period` changes take effect only at the next packet start.
- `pkt_seq` is the same value as `pkt_count` before its increment. It wraps at 2^32 with no flag. `late_count` wraps the same way.
- `pkt_seq` is not cleared on re-enable, only by reset.

## Timing

- Reset values: all outputs 0, state IDLE, `pkt_seq`, timer and counters all 0.
- All outputs are registered.
- `tx_afull` sampled high in cycle t means no word is issued in cycle t+1 (`tx_valid`=0 in t+1). Words are never duplicated or skipped across a stall.
- `enable` rising in cycle t gives the first `tx_valid` in cycle t+2 (IDLE→SEND in t+1, word registered in t+2), when `tx_afull`=0.
- With no stall, a packet occupies exactly len consecutive `tx_valid` cycles.
- Start-to-start spacing equals `max(period, len)` cycles when unstalled.
- `pkt_count` updates in the same cycle `tx_eof` is high.
- Reset asserted mid-packet:
  - Outputs drop to 0 immediately (asynchronously).
  - The partial packet is abandoned; the TGE core is responsible for discarding the runt.

## Structure

- Shared package `tge_pkt_sim_pkg`:
  - state enum (IDLE, SEND, GAP);
  - `TX_W` = 64;
  - the `tx_data` field-packing function.
- One natural sub-module, `tge_pkt_sim_timer`: period counter plus saturate and "due" compare. Everything else stays in the top-level FSM.

## Test plan

- **Basic stream.** `payload_len`=4, `period`=10, enable for 50 cycles, no stall.
  - Expect 4-word packets starting 10 cycles apart.
  - `tx_data` low words 0..3, `tx_eof` on word 3.
  - Sequence numbers increment by 1.
- **Back-to-back.** `payload_len`=8, `period`=3.
  - Expect zero-gap packets.
  - `late_count` increments by 1 per packet.
  - Spacing is 8 cycles.
- **Backpressure.** `payload_len`=6; hold `tx_afull` high for 5 cycles mid-packet.
  - `tx_valid` is low for exactly those 5 cycles (one-cycle offset).
  - Words 0..5 are all issued once, in order.
- **Disable mid-packet.** Drop `enable` on word 2 of a 10-word packet.
  - Packet completes through `tx_eof`.
  - `busy`=0 the following cycle and no further `tx_valid`.
- **Zero fields.** `payload_len`=0, `period`=0.
  - Every word is a single-word packet with `tx_eof`=1, issued every cycle.
  - `pkt_count` increments each cycle.
- **Async reset mid-packet.** Assert `user_rst_n`=0 during word 3.
  - All outputs are 0 within the same cycle.
  - After release and enable, the first packet has `pkt_seq`=0.

Source files
------------

// File: rtl/tge_pkt_sim_pkg.sv
// Shared definitions for the tge packet-simulator controller: FSM encodings,
// tx word width and the tx_data field layout.
package tge_pkt_sim_pkg;

   localparam int TX_W = 64;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SEND = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

   function automatic logic [TX_W-1:0] pack_tx_data(input logic [31:0] pkt_seq,
                                                    input logic [31:0] word_idx);
      return {pkt_seq, word_idx};
   endfunction

endpackage

// File: rtl/tge_pkt_sim_timer.sv
// Start-to-start period timer: loaded with period-1 at each packet start and
// counted down to a saturating terminal count, which marks the next start as due.
module tge_pkt_sim_timer #(
   parameter int PER_W = 32
) (
   input  logic             user_clk,
   input  logic             user_rst_n,
   input  logic             load,
   input  logic [PER_W-1:0] load_val,
   output logic             due,
   output logic             due_first
);

   logic [PER_W-1:0] count;
   logic             fired;

   always_ff @(posedge user_clk or negedge user_rst_n) begin
      if (!user_rst_n) begin
         count <= '0;
         fired <= 1'b0;
      end else if (load) begin
         count <= load_val;
         fired <= 1'b0;
      end else begin
         if (count != '0) count <= count - PER_W'(1);
         if (count == '0) fired <= 1'b1;
      end
   end

   assign due       = (count == '0);
   // due_first marks only the first due cycle of each period, so lateness counts once
   assign due_first = due && !fired;

endmodule

// File: rtl/tge_pkt_sim_ctrl.sv
// Packet-simulator controller: emits fixed-length test packets at a programmable
// start-to-start period, honouring tx almost-full backpressure.
//
// state | meaning
// IDLE  | waiting for enable; no output activity
// SEND  | issuing packet words, one per cycle without almost-full
// GAP   | packet done, waiting for the period to come due or enable to drop
module tge_pkt_sim_ctrl
   import tge_pkt_sim_pkg::*;
#(
   parameter int LEN_W = 16,
   parameter int PER_W = 32
) (
   input  logic             user_clk,
   input  logic             user_rst_n,
   input  logic             enable,
   input  logic [LEN_W-1:0] payload_len,
   input  logic [PER_W-1:0] period,
   input  logic             tx_afull,
   output logic             tx_valid,
   output logic [TX_W-1:0]  tx_data,
   output logic             tx_eof,
   output logic [31:0]      pkt_count,
   output logic [31:0]      late_count,
   output logic             busy
);

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [LEN_W-1:0] len_m1;
   logic [LEN_W-1:0] len_m1_new;
   logic [PER_W-1:0] per_m1_new;
   logic [31:0]      word_idx;
   logic             issue;
   logic             last;
   logic             start;
   logic             due;
   logic             due_first;
   logic             late_inc;

   assign len_m1_new = (payload_len == '0) ? '0 : payload_len - LEN_W'(1);
   assign per_m1_new = (period == '0) ? '0 : period - PER_W'(1);
   assign issue      = (state == ST_SEND) && !tx_afull;
   assign last       = (word_idx == 32'(len_m1));
   // a period falling due on the eof cycle itself is on time, not late
   assign late_inc   = (state == ST_SEND) && due_first && !(issue && last);

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (enable) begin
               state_nxt = ST_SEND;
               start     = 1'b1;
            end
         end
         ST_SEND: begin
            if (issue && last) begin
               if (enable && due) start = 1'b1;
               else               state_nxt = ST_GAP;
            end
         end
         ST_GAP: begin
            if (!enable) begin
               state_nxt = ST_IDLE;
            end else if (due) begin
               state_nxt = ST_SEND;
               start     = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   tge_pkt_sim_timer #(.PER_W(PER_W)) u_timer (
      .user_clk   (user_clk),
      .user_rst_n (user_rst_n),
      .load       (start),
      .load_val   (per_m1_new),
      .due        (due),
      .due_first  (due_first)
   );

   always_ff @(posedge user_clk or negedge user_rst_n) begin
      if (!user_rst_n) begin
         state      <= ST_IDLE;
         len_m1     <= '0;
         word_idx   <= '0;
         tx_valid   <= 1'b0;
         tx_data    <= '0;
         tx_eof     <= 1'b0;
         pkt_count  <= '0;
         late_count <= '0;
         busy       <= 1'b0;
      end else begin
         state    <= state_nxt;
         busy     <= (state_nxt != ST_IDLE);
         tx_valid <= issue;
         tx_eof   <= issue && last;
         if (issue) begin
            tx_data  <= pack_tx_data(pkt_count, word_idx);
            word_idx <= word_idx + 32'd1;
            if (last) pkt_count <= pkt_count + 32'd1;
         end
         if (late_inc) late_count <= late_count + 32'd1;
         if (start) begin
            len_m1   <= len_m1_new;
            word_idx <= '0;
         end
      end
   end

endmodule
